// File: rtl/block_minmax_writer_pkg.sv
// -----------------------------------------------------------------------------
// block_minmax_writer_pkg
// Shared constants and types for the 4x4 block min/max writer.
//   Frame geometry : 320x240 pixels, raster order
//   Block geometry : 4x4 pixels -> 80 columns x 60 rows = 4800 blocks
//   Defaults       : PIX_W (pixel width), ADDR_W (block-memory address width)
//   state_t        : writer FSM state (IDLE / ACTIVE)
// -----------------------------------------------------------------------------
package block_minmax_writer_pkg;

   localparam int IMG_W    = 320;
   localparam int IMG_H    = 240;
   localparam int BLK      = 4;
   localparam int BLK_COLS = IMG_W / BLK;          // 80
   localparam int BLK_ROWS = IMG_H / BLK;          // 60
   localparam int NUM_BLK  = BLK_COLS * BLK_ROWS;  // 4800
   localparam int PIX_W    = 4;
   localparam int ADDR_W   = 13;

   // Counter widths derived from the geometry
   localparam int X_W  = $clog2(IMG_W);     // 9
   localparam int Y_W  = $clog2(IMG_H);     // 8
   localparam int BX_W = $clog2(BLK_COLS);  // 7
   localparam int BY_W = $clog2(BLK_ROWS);  // 6

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/block_minmax_writer_line_buf.sv
// -----------------------------------------------------------------------------
// minmax_line_buf
// One entry per block column, holding the running {max, min} of the block
// rows seen so far. Combinational read, synchronous write, no reset (the
// first pixel row of each block row overwrites whatever is stored).
//   clk            : clock
//   we             : write enable
//   wr_idx         : entry to write
//   wr_min/wr_max  : values written
//   rd_idx         : entry to read
//   rd_min/rd_max  : values read (combinational)
// -----------------------------------------------------------------------------
module minmax_line_buf #(
   parameter int PIX_W = 4,
   parameter int DEPTH = 80,
   parameter int IDX_W = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [PIX_W-1:0] wr_min,
   input  logic [PIX_W-1:0] wr_max,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [PIX_W-1:0] rd_min,
   output logic [PIX_W-1:0] rd_max
);

   // Flattened view of all entries, {max, min} per entry
   logic [DEPTH-1:0][2*PIX_W-1:0] entry_bus;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [2*PIX_W-1:0] entry_reg;

         always_ff @(posedge clk) begin
            if (we && (wr_idx == IDX_W'(gi))) begin
               entry_reg <= {wr_max, wr_min};
            end
         end

         assign entry_bus[gi] = entry_reg;
      end
   endgenerate

   assign rd_min = entry_bus[rd_idx][PIX_W-1:0];
   assign rd_max = entry_bus[rd_idx][2*PIX_W-1:PIX_W];

endmodule

// File: rtl/block_minmax_writer.sv
// -----------------------------------------------------------------------------
// block_minmax_writer
// Computes min and max of every 4x4 block of a 320x240 raster stream and
// writes them to a block memory, one write per completed block.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pix_valid, pix_data : pixel stream (one pixel per clock max)
//   sof                 : start of frame, qualified by pix_valid
//   wea, addr_write     : write strobe and block index (by*80+bx)
//   din_max, din_min    : block max/min, held between writes
//   frame_done          : pulses with the write of the last block
//   frame_err           : pulses the cycle after a mid-frame sof
//   busy                : frame in progress
// -----------------------------------------------------------------------------
module block_minmax_writer #(
   parameter int PIX_W  = block_minmax_writer_pkg::PIX_W,
   parameter int ADDR_W = block_minmax_writer_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              sof,
   output logic              wea,
   output logic [ADDR_W-1:0] addr_write,
   output logic [PIX_W-1:0]  din_max,
   output logic [PIX_W-1:0]  din_min,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   import block_minmax_writer_pkg::*;

   function automatic logic [PIX_W-1:0] pmin(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [PIX_W-1:0] pmax(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   state_t             state_reg;
   logic [X_W-1:0]     x_reg;
   logic [Y_W-1:0]     y_reg;
   logic [PIX_W-1:0]   hmin_reg, hmax_reg;
   logic               wea_reg, frame_done_reg, frame_err_reg, busy_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic [PIX_W-1:0]   dmin_reg, dmax_reg;

   // Current pixel position; an sof pixel is always (0,0), even mid-frame
   logic               take;
   logic [X_W-1:0]     x_cur;
   logic [Y_W-1:0]     y_cur;
   logic [BX_W-1:0]    bx;
   logic [BY_W-1:0]    by;
   logic               col_last, row_last, px_last;
   logic [PIX_W-1:0]   hmin_next, hmax_next;
   logic [PIX_W-1:0]   vmin_next, vmax_next;
   logic [PIX_W-1:0]   lb_min, lb_max;
   logic [ADDR_W-1:0]  addr_next;

   assign take     = pix_valid && (sof || (state_reg == ST_ACTIVE));
   assign x_cur    = sof ? '0 : x_reg;
   assign y_cur    = sof ? '0 : y_reg;
   assign bx       = x_cur[X_W-1:2];
   assign by       = y_cur[Y_W-1:2];
   assign col_last = (x_cur[1:0] == 2'(BLK-1));
   assign row_last = (y_cur[1:0] == 2'(BLK-1));
   assign px_last  = (x_cur == X_W'(IMG_W-1)) && (y_cur == Y_W'(IMG_H-1));

   // Horizontal 4-pixel run: restart at the left pixel of each block
   assign hmin_next = (x_cur[1:0] == 2'd0) ? pix_data : pmin(hmin_reg, pix_data);
   assign hmax_next = (x_cur[1:0] == 2'd0) ? pix_data : pmax(hmax_reg, pix_data);

   // Vertical merge: the top row of a block row overwrites stale entries
   assign vmin_next = (y_cur[1:0] == 2'd0) ? hmin_next : pmin(lb_min, hmin_next);
   assign vmax_next = (y_cur[1:0] == 2'd0) ? hmax_next : pmax(lb_max, hmax_next);

   // by*80 + bx as two shifts and adds
   assign addr_next = (ADDR_W'(by) << 6) + (ADDR_W'(by) << 4) + ADDR_W'(bx);

   minmax_line_buf #(
      .PIX_W (PIX_W),
      .DEPTH (BLK_COLS),
      .IDX_W (BX_W)
   ) u_line_buf (
      .clk    (clk),
      .we     (take && col_last),
      .wr_idx (bx),
      .wr_min (vmin_next),
      .wr_max (vmax_next),
      .rd_idx (bx),
      .rd_min (lb_min),
      .rd_max (lb_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         x_reg          <= '0;
         y_reg          <= '0;
         hmin_reg       <= '0;
         hmax_reg       <= '0;
         wea_reg        <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         busy_reg       <= 1'b0;
         addr_reg       <= '0;
         dmin_reg       <= '0;
         dmax_reg       <= '0;
      end else begin
         wea_reg        <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= pix_valid && sof && (state_reg == ST_ACTIVE);

         if (take) begin
            hmin_reg <= hmin_next;
            hmax_reg <= hmax_next;

            if (px_last) begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               x_reg     <= '0;
               y_reg     <= '0;
            end else begin
               state_reg <= ST_ACTIVE;
               busy_reg  <= 1'b1;
               if (x_cur == X_W'(IMG_W-1)) begin
                  x_reg <= '0;
                  y_reg <= y_cur + Y_W'(1);
               end else begin
                  x_reg <= x_cur + X_W'(1);
                  y_reg <= y_cur;
               end
            end

            if (col_last && row_last) begin
               wea_reg        <= 1'b1;
               addr_reg       <= addr_next;
               dmin_reg       <= vmin_next;
               dmax_reg       <= vmax_next;
               frame_done_reg <= (addr_next == ADDR_W'(NUM_BLK-1));
            end
         end
      end
   end

   assign wea        = wea_reg;
   assign addr_write = addr_reg;
   assign din_min    = dmin_reg;
   assign din_max    = dmax_reg;
   assign frame_done = frame_done_reg;
   assign frame_err  = frame_err_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_block_minmax_writer.sv
// -----------------------------------------------------------------------------
// tb_block_minmax_writer
// Directed frames with closed-form expected block values:
//   mode 0 : every pixel 7
//   mode 1 : pixel = x mod 16
//   mode 2 : all zero except pixel (5,9) = 15
// Outputs are compared every cycle, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_block_minmax_writer;

   localparam int PIX_W  = 4;
   localparam int ADDR_W = 13;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              sof;
   logic              wea;
   logic [ADDR_W-1:0] addr_write;
   logic [PIX_W-1:0]  din_max;
   logic [PIX_W-1:0]  din_min;
   logic              frame_done;
   logic              frame_err;
   logic              busy;

   always #5 clk = ~clk;

   block_minmax_writer #(
      .PIX_W  (PIX_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .sof        (sof),
      .wea        (wea),
      .addr_write (addr_write),
      .din_max    (din_max),
      .din_min    (din_min),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: frame position and last expected write
   bit m_active = 0;
   int mx = 0, my = 0;
   bit e_wea = 0, e_done = 0, e_err = 0;
   int e_addr = 0, e_min = 0, e_max = 0;
   int n_writes = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pix_of(input int mode, input int x, input int y);
      case (mode)
         0:       return 7;
         1:       return x % 16;
         default: return (x == 5 && y == 9) ? 15 : 0;
      endcase
   endfunction

   function automatic int blk_min(input int mode, input int bx, input int by);
      case (mode)
         0:       return 7;
         1:       return (4 * bx) % 16;
         default: return 0;
      endcase
   endfunction

   function automatic int blk_max(input int mode, input int bx, input int by);
      case (mode)
         0:       return 7;
         1:       return (4 * bx + 3) % 16;
         default: return (bx == 1 && by == 2) ? 15 : 0;
      endcase
   endfunction

   task automatic check_outputs();
      check_eq("wea",        int'(wea),        int'(e_wea));
      check_eq("addr_write", int'(addr_write), e_addr);
      check_eq("din_min",    int'(din_min),    e_min);
      check_eq("din_max",    int'(din_max),    e_max);
      check_eq("frame_done", int'(frame_done), int'(e_done));
      check_eq("frame_err",  int'(frame_err),  int'(e_err));
      check_eq("busy",       int'(busy),       int'(m_active));
   endtask

   // One clock cycle: drive inputs, predict, advance, compare
   task automatic step(input bit v, input bit s, input int mode);
      int  cx, cy;
      bit  take;
      take      = v && (m_active || s);
      cx        = s ? 0 : mx;
      cy        = s ? 0 : my;
      pix_valid = v;
      sof       = s;
      pix_data  = v ? PIX_W'(pix_of(mode, cx, cy)) : PIX_W'($urandom_range(0, 15));
      e_err     = v && s && m_active;
      e_wea     = 1'b0;
      e_done    = 1'b0;
      if (take) begin
         if ((cx % 4) == 3 && (cy % 4) == 3) begin
            e_wea  = 1'b1;
            e_addr = (cy / 4) * 80 + cx / 4;
            e_min  = blk_min(mode, cx / 4, cy / 4);
            e_max  = blk_max(mode, cx / 4, cy / 4);
            e_done = (e_addr == 4799);
         end
         if (cx == 319 && cy == 239) begin
            m_active = 1'b0;
            mx = 0;
            my = 0;
         end else begin
            m_active = 1'b1;
            if (cx == 319) begin
               mx = 0;
               my = cy + 1;
            end else begin
               mx = cx + 1;
               my = cy;
            end
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
      if (e_wea) n_writes++;
      pix_valid = 1'b0;
      sof       = 1'b0;
   endtask

   // Asynchronous reset: outputs must clear before any clock edge
   task automatic do_reset();
      rst_n    = 1'b0;
      m_active = 1'b0;
      mx = 0;
      my = 0;
      e_wea = 0; e_done = 0; e_err = 0;
      e_addr = 0; e_min = 0; e_max = 0;
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      pix_data  = '0;
      #2;
      do_reset();
      $display("[TB] reset: outputs cleared");

      // Pixels without sof while idle are ignored
      for (int i = 0; i < 6; i++) step(i < 4, 1'b0, 0);
      $display("[TB] idle: pixels without sof ignored");

      // Constant frame, 8 full rows plus 40 pixels into row 8
      n_writes = 0;
      step(1'b1, 1'b1, 0);
      for (int i = 1; i < 2600; i++) step(1'b1, 1'b0, 0);
      check_eq("writes_const", n_writes, 160);
      $display("[TB] const frame: %0d block writes", n_writes);

      // Mid-frame sof restarts with the single-hot frame and ~30% idle gaps
      n_writes = 0;
      step(1'b1, 1'b1, 2);
      for (int i = 1; i < 12 * 320 + 100; i++) begin
         if ($urandom_range(0, 99) < 30) step(1'b0, 1'b0, 2);
         step(1'b1, 1'b0, 2);
      end
      check_eq("writes_hot", n_writes, 240);
      $display("[TB] restart + gaps: %0d block writes", n_writes);

      // Reset mid-frame, then pixels without sof produce nothing
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2);
      $display("[TB] mid-frame reset: no writes until sof");

      // Full frame of x mod 16 to the last block
      n_writes = 0;
      step(1'b1, 1'b1, 1);
      for (int i = 1; i < 320 * 240; i++) step(1'b1, 1'b0, 1);
      check_eq("writes_full", n_writes, 4800);
      $display("[TB] full frame: %0d block writes", n_writes);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1);

      // A new sof after a completed frame is a clean start
      step(1'b1, 1'b1, 0);
      step(1'b1, 1'b0, 0);
      $display("[TB] new frame after completion started");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
